// File: rtl/spmm_pkg.sv
// Shared types and sizing for the SpMM LHS encoder: matrix geometry,
// element type and encoder FSM states.
package spmm_pkg;
    localparam int N     = 16;
    localparam int W     = 8;
    localparam int LGN   = $clog2(N);
    localparam int DBLGN = 2 * $clog2(N);

    typedef logic [W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        SEND   = 2'd2
    } state_t;
endpackage

// File: rtl/spmm_lhs_encoder_row_compactor.sv
// Combinational row compactor: flags nonzero lanes and gives each one its
// destination slot in the nonzero store (base + number of nonzeros before it).
module row_compactor
    import spmm_pkg::*;
(
    input  logic [N-1:0][W-1:0]   i_row,
    input  logic [DBLGN:0]        i_base,
    output logic [N-1:0]          o_mask,
    output logic [N-1:0][DBLGN:0] o_dest,
    output logic [LGN:0]          o_count
);
    logic [LGN:0] w_acc;

    always_comb begin
        o_mask = '0;
        o_dest = '0;
        w_acc  = '0;
        for (int j = 0; j < N; j++) begin
            o_mask[j] = (i_row[j] != '0);
            o_dest[j] = i_base + (DBLGN+1)'(w_acc);
            w_acc     = w_acc + (LGN+1)'(o_mask[j]);
        end
        o_count = w_acc;
    end
endmodule

// File: rtl/spmm_lhs_encoder.sv
// Host-side LHS transmitter: compacts a dense NxN matrix (one row per cycle)
// into CSR-style beats and presents them on an lhs_start/lhs_ready handshake.
module spmm_lhs_encoder
    import spmm_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    row_valid,
    output logic                    row_ready,
    input  logic [N-1:0][W-1:0]     row_data,
    input  logic                    lhs_ready,
    output logic                    lhs_start,
    output logic [N-1:0][DBLGN-1:0] lhs_ptr,
    output logic [N-1:0][LGN-1:0]   lhs_col,
    output logic [N-1:0][W-1:0]     lhs_data,
    output logic                    beat_last,
    output logic [DBLGN:0]          nnz_total,
    output logic                    busy,
    output logic                    done,
    output state_t                  dbg_state
);
    // Handshakes: a row moves on row_valid && row_ready, a beat moves on
    // lhs_start && lhs_ready; the sender holds everything stable until then.
    state_t                  r_state, w_next;
    logic [LGN-1:0]          r_row;
    logic [DBLGN:0]          r_wp;
    logic [LGN-1:0]          r_beat;
    logic                    r_done;
    logic [N-1:0][DBLGN-1:0] r_ptr;
    data_t                   r_store_data [N*N];
    logic [LGN-1:0]          r_store_col  [N*N];

    logic                    w_row_xfer;
    logic                    w_beat_xfer;
    logic                    w_is_last;
    logic [LGN-1:0]          w_last_beat;
    logic [DBLGN:0]          w_base;
    logic [DBLGN:0]          w_wp_next;
    logic [N-1:0]            w_mask;
    logic [N-1:0][DBLGN:0]   w_dest;
    logic [LGN:0]            w_count;

    // Row 0 of a new matrix always starts at slot 0, whatever the last matrix left.
    assign w_base      = (r_state == IDLE) ? '0 : r_wp;
    assign w_wp_next   = w_base + (DBLGN+1)'(w_count);
    assign w_row_xfer  = row_valid && row_ready;
    assign w_beat_xfer = lhs_start && lhs_ready;
    assign w_last_beat = (r_wp == '0) ? '0 : LGN'((r_wp - 1'b1) >> LGN);
    assign w_is_last   = (r_beat == w_last_beat);

    row_compactor u_row_compactor (
        .i_row   (row_data),
        .i_base  (w_base),
        .o_mask  (w_mask),
        .o_dest  (w_dest),
        .o_count (w_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        row_ready = 1'b0;
        lhs_start = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                row_ready = 1'b1;
                if (row_valid) w_next = ENCODE;
            end
            ENCODE: begin
                row_ready = 1'b1;
                busy      = 1'b1;
                if (row_valid && r_row == LGN'(N-1)) w_next = SEND;
            end
            SEND: begin
                lhs_start = 1'b1;
                busy      = 1'b1;
                if (lhs_ready && w_is_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_row  <= '0;
            r_wp   <= '0;
            r_beat <= '0;
            r_done <= 1'b0;
            r_ptr  <= '0;
        end else begin
            r_done <= w_beat_xfer && w_is_last;
            if (w_row_xfer) begin
                // r_row wraps back to 0 after row N-1, ready for the next matrix.
                r_row        <= r_row + 1'b1;
                r_wp         <= w_wp_next;
                r_ptr[r_row] <= DBLGN'(w_wp_next);
                r_beat       <= '0;
            end
            if (w_beat_xfer) r_beat <= w_is_last ? '0 : r_beat + 1'b1;
        end
    end

    // Store needs no reset: slots at or beyond r_wp are masked on the way out.
    always_ff @(posedge clock) begin
        for (int j = 0; j < N; j++) begin
            if (w_row_xfer && w_mask[j]) begin
                r_store_data[w_dest[j][DBLGN-1:0]] <= row_data[j];
                r_store_col[w_dest[j][DBLGN-1:0]]  <= LGN'(j);
            end
        end
    end

    always_comb begin
        lhs_data = '0;
        lhs_col  = '0;
        for (int i = 0; i < N; i++) begin
            if (r_state == SEND && {1'b0, r_beat, LGN'(i)} < r_wp) begin
                lhs_data[i] = r_store_data[{r_beat, LGN'(i)}];
                lhs_col[i]  = r_store_col[{r_beat, LGN'(i)}];
            end
        end
    end

    assign lhs_ptr   = r_ptr;
    assign beat_last = (r_state == SEND) && w_is_last;
    assign nnz_total = r_wp;
    assign done      = r_done;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_spmm_lhs_encoder.sv
// Bench for spmm_lhs_encoder: table of matrix cases plus random matrices,
// compared beat by beat against a CSR reference built from the matrix.
module tb_spmm_lhs_encoder;
    import spmm_pkg::*;

    logic                    clock;
    logic                    reset;
    logic                    row_valid;
    logic                    row_ready;
    logic [N-1:0][W-1:0]     row_data;
    logic                    lhs_ready;
    logic                    lhs_start;
    logic [N-1:0][DBLGN-1:0] lhs_ptr;
    logic [N-1:0][LGN-1:0]   lhs_col;
    logic [N-1:0][W-1:0]     lhs_data;
    logic                    beat_last;
    logic [DBLGN:0]          nnz_total;
    logic                    busy;
    logic                    done;
    state_t                  dbg_state;

    spmm_lhs_encoder dut (
        .clock     (clock),
        .reset     (reset),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .lhs_ready (lhs_ready),
        .lhs_start (lhs_start),
        .lhs_ptr   (lhs_ptr),
        .lhs_col   (lhs_col),
        .lhs_data  (lhs_data),
        .beat_last (beat_last),
        .nnz_total (nnz_total),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---- clock/reset ----
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---- case table ----
    typedef struct {
        int kind;        // 0 identity, 1 ones, 2 zero, 3 sparse, 4 twenty, 5 random
        int stall_beat;  // -1: pick at random
        int stall_len;
        int exp_nnz;     // -1: not fixed by hand
        int exp_beats;
        int exp_ptr15;
        int exp_d0;      // lane 0 data of beat 0
        int exp_c1;      // lane 1 col of beat 0
    } tcase_t;

    // ---- scoreboard state ----
    int total;
    int bad;
    logic [N-1:0][W-1:0] mat [N];
    logic [W-1:0]   exp_q[$];
    logic [LGN-1:0] exp_col_q[$];
    int m_ptr [N];
    int m_nnz;
    int m_nb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fill(input int kind);
        int p;
        for (int r = 0; r < N; r++) mat[r] = '0;
        case (kind)
            0: for (int r = 0; r < N; r++) mat[r][r] = 8'd5;
            1: for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mat[r][c] = 8'd1;
            3: begin
                mat[0][2] = 8'd3;
                mat[0][9] = 8'd7;
                mat[4][0] = 8'd1;
            end
            4: for (int r = 0; r < 10; r++) begin
                mat[r][r]   = W'(r + 1);
                mat[r][r+1] = W'(r + 1);
            end
            5: begin
                p = $urandom_range(0, 100);
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        if ($urandom_range(1, 100) <= p) mat[r][c] = W'($urandom_range(1, 255));
            end
            default: ;
        endcase
    endtask

    // CSR reference: walk the matrix row-major, list nonzeros, pad to whole beats.
    task automatic build_model();
        int cnt;
        exp_q     = {};
        exp_col_q = {};
        cnt = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (mat[r][c] != 0) begin
                    exp_q.push_back(mat[r][c]);
                    exp_col_q.push_back(LGN'(c));
                    cnt++;
                end
            end
            m_ptr[r] = cnt % (1 << DBLGN);
        end
        m_nnz = cnt;
        m_nb  = (cnt == 0) ? 1 : (cnt + N - 1) / N;
        while (exp_q.size() < m_nb * N) begin
            exp_q.push_back('0);
            exp_col_q.push_back('0);
        end
    endtask

    // ---- driver tasks ----
    task automatic drive_rows();
        for (int r = 0; r < N; r++) begin
            @(negedge clock);
            chk("row_ready_encode", row_ready, 1);
            row_valid = 1'b1;
            row_data  = mat[r];
            @(posedge clock);
        end
    endtask

    task automatic run_case(input tcase_t tc);
        int b;
        int cyc;
        int stall_left;
        int stall_beat;
        bit finished;
        bit last_seen;
        fill(tc.kind);
        build_model();
        stall_beat = (tc.stall_beat < 0) ? $urandom_range(0, m_nb - 1) : tc.stall_beat;
        stall_left = tc.stall_len;
        drive_rows();
        b = 0;
        cyc = 0;
        finished = 0;
        while (!finished && cyc < 300) begin
            @(negedge clock);
            cyc++;
            chk("lhs_start", lhs_start, 1);
            chk("row_ready_send", row_ready, 0);
            chk("busy_send", busy, 1);
            chk("state_send", 32'(dbg_state), 32'(SEND));
            if (b >= m_nb) begin
                chk("extra_beat", b, m_nb - 1);
                break;
            end
            for (int i = 0; i < N; i++) begin
                chk("lhs_data", lhs_data[i], exp_q[b*N + i]);
                chk("lhs_col", lhs_col[i], exp_col_q[b*N + i]);
                chk("lhs_ptr", lhs_ptr[i], m_ptr[i]);
            end
            chk("beat_last", beat_last, (b == m_nb - 1));
            chk("nnz_total", nnz_total, m_nnz);
            if (b == 0 && cyc == 1) begin
                if (tc.exp_nnz >= 0)   chk("nnz_hand", nnz_total, tc.exp_nnz);
                if (tc.exp_ptr15 >= 0) chk("ptr15_hand", lhs_ptr[N-1], tc.exp_ptr15);
                if (tc.exp_d0 >= 0)    chk("d0_hand", lhs_data[0], tc.exp_d0);
                if (tc.exp_c1 >= 0)    chk("c1_hand", lhs_col[1], tc.exp_c1);
            end
            if (b == stall_beat && stall_left > 0) begin
                lhs_ready = 1'b0;
                stall_left--;
            end else begin
                lhs_ready = 1'b1;
            end
            // Garbage rows during SEND must be ignored; drop them before the final beat.
            row_valid = (b != m_nb - 1);
            for (int i = 0; i < N; i++) row_data[i] = W'($urandom_range(0, 255));
            last_seen = beat_last;
            @(posedge clock);
            if (lhs_ready) begin
                b++;
                if (last_seen) finished = 1;
            end
        end
        if (!finished) chk("beat_timeout", 0, 1);
        chk("beat_count_model", b, m_nb);
        if (tc.exp_beats >= 0) chk("beat_count_hand", b, tc.exp_beats);
        @(negedge clock);
        lhs_ready = 1'b0;
        row_valid = 1'b0;
        chk("done_pulse", done, 1);
        chk("lhs_start_after", lhs_start, 0);
        chk("busy_after", busy, 0);
        chk("state_after", 32'(dbg_state), 32'(IDLE));
        @(negedge clock);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic reset_in_send();
        fill(0);
        drive_rows();
        @(negedge clock);
        row_valid = 1'b0;
        lhs_ready = 1'b0;
        chk("rst_pre_start", lhs_start, 1);
        reset = 1'b1;
        #1;
        chk("rst_async_start", lhs_start, 0);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_lhs_start", lhs_start, 0);
        chk("rst_nnz", nnz_total, 0);
        chk("rst_done", done, 0);
        chk("rst_row_ready", row_ready, 1);
        for (int i = 0; i < N; i++) begin
            chk("rst_data", lhs_data[i], 0);
            chk("rst_ptr", lhs_ptr[i], 0);
        end
        @(negedge clock);
        chk("rst_no_done", done, 0);
    endtask

    // ---- main ----
    initial begin
        tcase_t cases [11];
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        row_valid = 1'b0;
        row_data  = '0;
        lhs_ready = 1'b0;

        cases[0]  = '{0, 0, 0,  16,  1, 16, 5, 1};
        cases[1]  = '{1, 0, 0, 256, 16,  0, 1, 1};
        cases[2]  = '{2, 0, 0,   0,  1,  0, 0, 0};
        cases[3]  = '{3, 0, 0,   3,  1,  3, 3, 9};
        cases[4]  = '{4, 1, 3,  20,  2, 20, 1, 1};
        cases[5]  = '{5, -1, 2, -1, -1, -1, -1, -1};
        cases[6]  = '{5, -1, 1, -1, -1, -1, -1, -1};
        cases[7]  = '{5, -1, 3, -1, -1, -1, -1, -1};
        cases[8]  = '{5, -1, 0, -1, -1, -1, -1, -1};
        cases[9]  = '{1, 7, 2, 256, 16,  0, 1, 1};
        cases[10] = '{0, 0, 0,  16,  1, 16, 5, 1};

        repeat (2) @(negedge clock);
        chk("reset_row_ready", row_ready, 1);
        chk("reset_lhs_start", lhs_start, 0);
        chk("reset_beat_last", beat_last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_nnz", nnz_total, 0);
        chk("reset_state", 32'(dbg_state), 32'(IDLE));
        chk("reset_ptr0", lhs_ptr[0], 0);
        chk("reset_data0", lhs_data[0], 0);
        reset = 1'b0;

        for (int k = 0; k < 10; k++) run_case(cases[k]);
        reset_in_send();
        run_case(cases[10]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
